// File: rtl/otter_rf_pkg.sv
// Shared types for the OTTER register-file write path: the write-port bundle,
// the grant select, and register-index helpers.
package otter_rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int RF_XLEN    = 32;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [RF_XLEN-1:0]    data;
    } rf_wr_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_MC
    } wb_src_e;

    // x0 is hardwired to zero, so it never takes a write or a busy mark.
    function automatic logic is_real_reg(input logic [REG_ADDR_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/otter_scoreboard.sv
// Per-register busy vector for outstanding multi-cycle results, with
// set-over-clear priority and a combinational lookup for the issuing op.
module otter_scoreboard
    import otter_rf_pkg::*;
(
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_idx,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_idx,
    input  logic [REG_ADDR_W-1:0] lookup_idx,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  lookup_busy
);

    logic [NUM_REGS-1:0] busy_next;

    // Clear is applied before set so a same-cycle set on the same register wins.
    always_comb begin
        busy_next = busy;
        if (clr_en) begin
            busy_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            busy_next[set_idx] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign lookup_busy = busy[lookup_idx];

endmodule

// File: rtl/otter_rf_write_arbiter.sv
// Shares the register-file write port between pipeline writeback and the
// multi-cycle unit: fixed priority to writeback with a starvation-forced grant.
module otter_rf_write_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clock,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            wb_ready,
    input  logic            mc_valid,
    input  logic [4:0]      mc_rd,
    input  logic [XLEN-1:0] mc_data,
    output logic            mc_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    output logic [31:0]     busy,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd
);
    import otter_rf_pkg::*;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]      wait_cnt;
    logic                  force_mc;
    logic                  wb_accept;
    logic                  mc_accept;
    wb_src_e               grant;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;
    logic                  iss_set;
    logic                  iss_hit_busy;
    rf_wr_t                rf_wr_q;

    // Once the multi-cycle unit has lost MAX_WAIT times in a row it owns the port
    // for one cycle, even if the pipeline is requesting.
    always_comb begin
        force_mc  = (wait_cnt == WAIT_LIMIT);
        wb_ready  = !force_mc;
        mc_ready  = force_mc || (mc_valid && !wb_valid);
        wb_accept = wb_valid && wb_ready;
        mc_accept = mc_valid && mc_ready;

        grant    = SRC_NONE;
        sel_rd   = '0;
        sel_data = '0;
        if (mc_accept) begin
            grant    = SRC_MC;
            sel_rd   = mc_rd;
            sel_data = mc_data;
        end else if (wb_accept) begin
            grant    = SRC_WB;
            sel_rd   = wb_rd;
            sel_data = wb_data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!mc_valid || mc_accept) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Address and data only move on a real write, so the port holds its last
    // value while rf_we is low.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_q <= '0;
        end else begin
            rf_wr_q.we <= 1'b0;
            if (grant != SRC_NONE && is_real_reg(sel_rd)) begin
                rf_wr_q.we   <= 1'b1;
                rf_wr_q.addr <= sel_rd;
                rf_wr_q.data <= sel_data;
            end
        end
    end

    assign rf_we = rf_wr_q.we;
    assign rf_wa = rf_wr_q.addr;
    assign rf_wd = rf_wr_q.data;

    assign iss_ready = !iss_hit_busy;
    assign iss_set   = iss_valid && iss_ready && is_real_reg(iss_rd);

    otter_scoreboard u_scoreboard (
        .clock       (clock),
        .rst_n       (rst_n),
        .set_en      (iss_set),
        .set_idx     (iss_rd),
        .clr_en      (mc_accept),
        .clr_idx     (mc_rd),
        .lookup_idx  (iss_rd),
        .busy        (busy),
        .lookup_busy (iss_hit_busy)
    );

endmodule
